bldc_commutator: RTL
====================

// Module: bldc_commutator
// PURPOSE
//  Six-step BLDC commutation sequencer between the hall inputs and the 3-phase gate driver (INHA..INLC).
//  Filters the hall code, maps it to a sector and gates the PWM block output onto the active high-side switch.
//  Inserts dead time on every pattern change, detects invalid-hall and stall faults, and tracks commutation steps.
// PARAMETERS
//  DEADTIME_CYCLES  32         all-off cycles between drive patterns (1 us @ 32 MHz); must be >= 1
//  HALL_FILTER      4          consecutive identical synced samples needed to accept a hall code; must be >= 1
//  STALL_CYCLES     3_200_000  DRIVE cycles without a sector change before a stall fault; 0 = disabled
// PORTS
//  CLK                input   1   system clock (clk32MHz domain)
//  reset              input   1   synchronous, active-high reset
//  hall               input   3   raw asynchronous hall inputs {h3,h2,h1}
//  pwm_in             input   1   PWM waveform from the pwm block
//  dir                input   1   0 = forward, 1 = reverse
//  enable             input   1   1 = drive the motor
//  clear_fault        input   1   level; leaves FAULT only while enable=0
//  INHA,INLA,INHB,INLB,INHC,INLC  output  1 each  gate drive, registered
//  sector             output  3   accepted sector 0..5; 7 = invalid or none yet
//  state              output  2   0 IDLE, 1 DEADTIME, 2 DRIVE, 3 FAULT
//  fault              output  2   0 none, 1 invalid hall, 2 stall; held until cleared
//  commutation_count  output 24   signed, net sector steps
// BEHAVIOUR
//  Reset: all gate outputs 0, sector=7, state=IDLE, fault=0, commutation_count=0, filter and counters cleared.
//   Reset wins over every other event, including mid-DEADTIME.
//  Hall path:
//   - 2-flop synchronizer, then filter. The accepted code updates only after HALL_FILTER consecutive equal samples.
//   - Latency from a hall edge to sector update is 2+HALL_FILTER cycles.
//  Sector decode: 101->0, 100->1, 110->2, 010->3, 011->4, 001->5; 000/111 -> 7 (invalid).
//  Forward table (high phase gets PWM / low phase static on):
//   s0 A/B, s1 A/C, s2 B/C, s3 B/A, s4 C/A, s5 C/B. Reverse swaps high and low phases.
//  Gating: INHx = registered(pwm_in & hi_sel_x); INLx = registered lo_sel_x. Floating phase is 0/0.
//   1-cycle latency from pwm_in. INHx and INLx are never both 1.
//  FSM:
//   - IDLE: outputs 0. enable=1 & sector!=7 -> DEADTIME. enable=1 & sector=7 -> FAULT, fault=1.
//   - DEADTIME: outputs 0 for exactly DEADTIME_CYCLES cycles. Then latch pattern(sector,dir) -> DRIVE.
//     Changes during DEADTIME do not restart the count; the pattern is sampled at expiry.
//   - DRIVE: drive the latched pattern. A new pattern (sector or dir change) -> DEADTIME.
//   - FAULT: outputs 0. clear_fault=1 & enable=0 -> IDLE with fault=0; otherwise stay.
//   - In DEADTIME or DRIVE: enable=0 -> IDLE, outputs 0 on the next edge.
//  Fault conditions and priority:
//   - sector=7 in DEADTIME or DRIVE -> FAULT, fault=1.
//   - Stall counter clears on each sector change and on entry to DRIVE; it counts every DRIVE cycle.
//     Reaching STALL_CYCLES -> FAULT, fault=2.
//   - Same-cycle priority: reset > invalid hall > stall > enable=0 > pattern change.
//  commutation_count: +1 when sector goes s->(s+1)%6; -1 when s->(s+5)%6.
//   - Other jumps, or transitions to/from 7: no change.
//   - Updates in every state except reset; wraps in two's complement.
// TESTING (bench params: DEADTIME_CYCLES=4, HALL_FILTER=2, STALL_CYCLES=100)
//  1. hall=101, dir=0, pwm_in=1, enable 0->1 -> state=1 for 4 cycles, outputs 0; then INHA=1, INLB=1, rest 0, state=2.
//  2. In DRIVE, hall 101->100 -> after 4 cycles accept, all outputs 0 for exactly 4 cycles, then INHA=pwm, INLC=1; count=+1.
//  3. Six backward steps 101,001,011,010,110,100,101 -> count=-6. dir=1 at s0 -> INHB=pwm, INLA=1 after 4 off cycles.
//  4. hall=111 in DRIVE -> FAULT, fault=1, outputs 0. clear_fault=1 with enable=1 -> no exit. enable=0 -> IDLE, fault=0.
//  5. Hall held constant 100 DRIVE cycles -> fault=2, state=3 on cycle 100; toggling pwm_in never reaches INHx.
//  6. 1-cycle hall glitch -> no sector, count or deadtime change. Reset asserted mid-DEADTIME -> next edge: IDLE, count=0, outputs 0.

Source files
------------

// File: rtl/bldc_commutator_if.sv
// Hall/PWM inputs, gate drive and status for the six-step commutator.
// slave is the commutator side; master is the controller/driver side.
interface bldc_commutator_if;
  logic [2:0]  hall;
  logic        pwm_in;
  logic        dir;
  logic        enable;
  logic        clear_fault;
  logic        INHA;
  logic        INLA;
  logic        INHB;
  logic        INLB;
  logic        INHC;
  logic        INLC;
  logic [2:0]  sector;
  logic [1:0]  state;
  logic [1:0]  fault;
  logic [23:0] commutation_count;

  modport slave (
    input  hall, pwm_in, dir, enable, clear_fault,
    output INHA, INLA, INHB, INLB, INHC, INLC,
    output sector, state, fault, commutation_count
  );

  modport master (
    output hall, pwm_in, dir, enable, clear_fault,
    input  INHA, INLA, INHB, INLB, INHC, INLC,
    input  sector, state, fault, commutation_count
  );
endinterface

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation: hall sync/filter, sector decode, dead time,
// invalid-hall and stall faults, signed commutation step counter.
module bldc_commutator #(
  parameter int DEADTIME_CYCLES = 32,
  parameter int HALL_FILTER     = 4,
  parameter int STALL_CYCLES    = 3_200_000
) (
  input  logic CLK,
  input  logic reset,
  bldc_commutator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [15:0] HF  = 16'(HALL_FILTER);
  localparam logic [15:0] DTL = 16'(DEADTIME_CYCLES - 1);
  localparam logic [31:0] STL = 32'(STALL_CYCLES);
  localparam bit          STALL_ON = (STALL_CYCLES != 0);

  // hall code -> sector, 7 for the two impossible codes
  function automatic logic [2:0] decode(input logic [2:0] code);
    logic [2:0] s;
    s = 3'd7;
    unique case (code)
      3'b101:  s = 3'd0;
      3'b100:  s = 3'd1;
      3'b110:  s = 3'd2;
      3'b010:  s = 3'd3;
      3'b011:  s = 3'd4;
      3'b001:  s = 3'd5;
      default: s = 3'd7;
    endcase
    return s;
  endfunction

  // {hi[C,B,A], lo[C,B,A]}; reverse swaps the high and low phase
  function automatic logic [5:0] pattern(
    input logic [2:0] s,
    input logic       rev
  );
    logic [2:0] hi;
    logic [2:0] lo;
    hi = 3'b000;
    lo = 3'b000;
    unique case (s)
      3'd0: begin hi = 3'b001; lo = 3'b010; end
      3'd1: begin hi = 3'b001; lo = 3'b100; end
      3'd2: begin hi = 3'b010; lo = 3'b100; end
      3'd3: begin hi = 3'b010; lo = 3'b001; end
      3'd4: begin hi = 3'b100; lo = 3'b001; end
      3'd5: begin hi = 3'b100; lo = 3'b010; end
      default: begin hi = 3'b000; lo = 3'b000; end
    endcase
    return rev ? {lo, hi} : {hi, lo};
  endfunction

  // {INHA,INLA,INHB,INLB,INHC,INLC} from a pattern and the pwm level
  function automatic logic [5:0] gate(
    input logic [5:0] p,
    input logic       pwm
  );
    return {pwm & p[3], p[0],
            pwm & p[4], p[1],
            pwm & p[5], p[2]};
  endfunction

  function automatic logic [2:0] inc6(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] dec6(input logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  last;
  logic [15:0] fcnt;
  logic [15:0] fcnt_nx;
  logic [2:0]  sector;
  logic [2:0]  new_sec;
  logic        accept;
  logic        sec_chg;
  logic        step_up;
  logic        step_dn;
  logic [23:0] count;

  state_t      st;
  logic [1:0]  flt;
  logic [15:0] dcnt;
  logic [31:0] stall;
  logic        stall_hit;
  logic [5:0]  pat;
  logic [5:0]  pat_q;
  logic [5:0]  g;

  // run length of identical synced samples and the sector step it implies
  always_comb begin
    fcnt_nx = 16'd1;
    if (sync2 == last) begin
      fcnt_nx = (fcnt >= HF) ? HF : fcnt + 16'd1;
    end
    accept  = (fcnt_nx >= HF);
    new_sec = decode(sync2);
    sec_chg = accept && (new_sec != sector);
    step_up = sec_chg && (sector != 3'd7) && (new_sec != 3'd7)
              && (new_sec == inc6(sector));
    step_dn = sec_chg && (sector != 3'd7) && (new_sec != 3'd7)
              && (new_sec == dec6(sector));
    pat       = pattern(sector, bus.dir);
    stall_hit = STALL_ON && ((stall + 32'd1) >= STL);
  end

  // hall synchronizer, filter, accepted sector and net step counter
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1  <= 3'd0;
      sync2  <= 3'd0;
      last   <= 3'd0;
      fcnt   <= 16'd0;
      sector <= 3'd7;
      count  <= 24'd0;
    end else begin
      sync1 <= bus.hall;
      sync2 <= sync1;
      last  <= sync2;
      fcnt  <= fcnt_nx;
      if (accept) begin
        sector <= new_sec;
      end
      if (step_up) begin
        count <= count + 24'd1;
      end else if (step_dn) begin
        count <= count - 24'd1;
      end
    end
  end

  // commutation FSM with registered gate drive, dead time and faults
  always_ff @(posedge CLK) begin
    if (reset) begin
      st    <= IDLE;
      flt   <= 2'd0;
      dcnt  <= 16'd0;
      stall <= 32'd0;
      pat_q <= 6'd0;
      g     <= 6'd0;
    end else begin
      g <= 6'd0;
      unique case (st)
        IDLE: begin
          if (bus.enable) begin
            if (sector == 3'd7) begin
              st  <= FAULT;
              flt <= 2'd1;
            end else begin
              st   <= DEAD;
              dcnt <= 16'd0;
            end
          end
        end
        DEAD: begin
          if (sector == 3'd7) begin
            st  <= FAULT;
            flt <= 2'd1;
          end else if (!bus.enable) begin
            st <= IDLE;
          end else if (dcnt >= DTL) begin
            st    <= DRIVE;
            pat_q <= pat;
            stall <= 32'd0;
            g     <= gate(pat, bus.pwm_in);
          end else begin
            dcnt <= dcnt + 16'd1;
          end
        end
        DRIVE: begin
          if (sector == 3'd7) begin
            st  <= FAULT;
            flt <= 2'd1;
          end else if (stall_hit) begin
            st  <= FAULT;
            flt <= 2'd2;
          end else if (!bus.enable) begin
            st <= IDLE;
          end else if (pat != pat_q) begin
            st   <= DEAD;
            dcnt <= 16'd0;
          end else begin
            g     <= gate(pat_q, bus.pwm_in);
            stall <= sec_chg ? 32'd0 : stall + 32'd1;
          end
        end
        FAULT: begin
          if (bus.clear_fault && !bus.enable) begin
            st  <= IDLE;
            flt <= 2'd0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.INHA              = g[5];
  assign bus.INLA              = g[4];
  assign bus.INHB              = g[3];
  assign bus.INLB              = g[2];
  assign bus.INHC              = g[1];
  assign bus.INLC              = g[0];
  assign bus.sector            = sector;
  assign bus.state             = st;
  assign bus.fault             = flt;
  assign bus.commutation_count = count;

endmodule
